mc_control_fsm: RTL

- Multicycle MIPS-subset control unit that sequences datapath enables and generates the 3-bit ALU function code consumed by the team's 32-bit ALU (F encoding: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT).
- Takes opcode, funct and the ALU zero flag from the datapath.
- Drives mux selects, write enables and F each cycle from a Moore FSM; PC enable has a Mealy term on zero.

---
 rtl/mc_pkg.sv | 51 +++++
 rtl/mc_control_fsm_alu_dec.sv | 24 ++
 rtl/mc_control_fsm.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS-subset control unit: states,
// opcodes, funct codes, ALU function codes and mux select values.
package mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BNEEX   = 4'd12,
    S_HALT    = 4'd13
  } state_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/mc_control_fsm_alu_dec.sv
// R-type funct decoder: maps funct to the ALU function code and flags
// any funct outside the supported set.
module mc_alu_dec
  import mc_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_f,
  output logic       legal
);

  always_comb begin
    alu_f = ALU_ADD;
    legal = 1'b1;
    case (funct)
      FN_ADD:  alu_f = ALU_ADD;
      FN_SUB:  alu_f = ALU_SUB;
      FN_AND:  alu_f = ALU_AND;
      FN_OR:   alu_f = ALU_OR;
      FN_SLT:  alu_f = ALU_SLT;
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/mc_control_fsm.sv
// Multicycle MIPS-subset control FSM (Moore outputs, Mealy PC enable on zero).
// Optional macro MC_BNE_EN adds the bne instruction; otherwise bne is illegal.
module mc_control_fsm
  import mc_pkg::*;
#(
  parameter bit HALT_ON_ILLEGAL = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic [2:0] alu_f,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       reg_write,
  output logic       illegal_op,
  output logic       halted
);

  state_e     state_q, state_d;
  logic [2:0] dec_f;
  logic       dec_legal;
  logic       pc_write_c, branch_c, bne_branch_c;
  logic       mem_write_c, ir_write_c, reg_write_c, illegal_c;

  mc_alu_dec u_alu_dec (
    .funct (funct),
    .alu_f (dec_f),
    .legal (dec_legal)
  );

  always_comb begin
    state_d      = state_q;
    alu_f        = ALU_ADD;
    alu_src_a    = 1'b0;
    alu_src_b    = SRCB_B;
    pc_src       = PC_ALU;
    pc_write_c   = 1'b0;
    branch_c     = 1'b0;
    bne_branch_c = 1'b0;
    iord         = 1'b0;
    mem_write_c  = 1'b0;
    ir_write_c   = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    reg_write_c  = 1'b0;
    illegal_c    = 1'b0;
    halted       = 1'b0;
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
        state_d    = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMMSH;
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     if (dec_legal) state_d = S_RTYPEEX; else illegal_c = 1'b1;
          OP_BEQ:       state_d = S_BEQEX;
          OP_ADDI:      state_d = S_ADDIEX;
          OP_J:         state_d = S_JEX;
`ifdef MC_BNE_EN
          OP_BNE:       state_d = S_BNEEX;
`endif
          default:      illegal_c = 1'b1;
        endcase
        if (illegal_c) state_d = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        // IR is held from DECODE on, so op still identifies lw vs sw here
        state_d   = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        iord    = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        mem_to_reg  = 1'b1;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_MEMWR: begin
        iord        = 1'b1;
        mem_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_RTYPEEX: begin
        alu_src_a = 1'b1;
        alu_f     = dec_f;
        state_d   = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        reg_dst     = 1'b1;
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_BEQEX, S_BNEEX: begin
        alu_src_a    = 1'b1;
        alu_f        = ALU_SUB;
        pc_src       = PC_ALUOUT;
        branch_c     = (state_q == S_BEQEX);
        bne_branch_c = (state_q == S_BNEEX);
        state_d      = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write_c = 1'b1;
        state_d     = S_FETCH;
      end
      S_JEX: begin
        pc_src     = PC_JUMP;
        pc_write_c = 1'b1;
        state_d    = S_FETCH;
      end
      S_HALT:  halted  = 1'b1;
      default: state_d = S_FETCH;
    endcase
  end

  // Enables are gated by rst_n so nothing writes while reset is held
  assign pc_en      = rst_n & (pc_write_c | (branch_c & zero) | (bne_branch_c & ~zero));
  assign ir_write   = rst_n & ir_write_c;
  assign mem_write  = rst_n & mem_write_c;
  assign reg_write  = rst_n & reg_write_c;
  assign illegal_op = rst_n & illegal_c;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

endmodule
